// File: rtl/mccomp_pkg.sv
// rtl/mccomp_pkg.sv - shared types and constants for the program loader
// Consumed by mem_loader and byte_packer; the CHK state is only reachable with LOADER_CHECKSUM_EN.
package mccomp_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

    localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHK,
        ST_COMMIT,
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - big-endian byte-to-word packer with a registered word_ready pulse
// word holds the completed word while word_ready is high.
module byte_packer
    import mccomp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  data,
    output logic [1:0]  idx,
    output logic [31:0] word,
    output logic        word_ready
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            word       <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= 1'b0;
            if (clear) begin
                idx <= '0;
            end else if (push) begin
                // MSB arrives first, so each byte shifts in from the bottom
                word       <= {word[23:0], data};
                idx        <= idx + 2'd1;
                word_ready <= (idx == LAST_BYTE_IDX);
            end
        end
    end

endmodule

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - byte-stream program loader for the multicycle MIPS memory, holds the CPU in reset
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module mem_loader
    import mccomp_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rstn,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [LEN_W:0] CAPACITY = (LEN_W + 1)'(1) << ADDR_W;

    loader_state_t      state;
    logic [7:0]         len_hi;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   word_cnt;
    logic [ADDR_W-1:0]  addr_cnt;
    logic               commit_wait;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         chk_acc;
`endif

    logic               accept;
    logic               restart;
    logic               last_word;
    logic [LEN_W-1:0]   len_now;
    logic [1:0]         pk_idx;
    logic [31:0]        pk_word;
    logic               pk_word_ready;

    assign accept    = rx_valid && rx_ready;
    assign restart   = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign len_now   = {len_hi, rx_data};
    assign last_word = (pk_idx == LAST_BYTE_IDX) && ((word_cnt + LEN_W'(1)) == len);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (restart),
        .push       (accept && (state == ST_DATA)),
        .data       (rx_data),
        .idx        (pk_idx),
        .word       (pk_word),
        .word_ready (pk_word_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rx_ready    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_rstn    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            len_hi      <= '0;
            len         <= '0;
            word_cnt    <= '0;
            addr_cnt    <= '0;
            commit_wait <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_acc     <= '0;
`endif
        end else begin
            // Writes trail the packer by one edge regardless of FSM state
            mem_we <= pk_word_ready;
            if (pk_word_ready) begin
                mem_wdata <= pk_word;
                mem_addr  <= addr_cnt;
                addr_cnt  <= addr_cnt + 1'b1;
            end

            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (restart) begin
                        state    <= ST_LEN_HI;
                        rx_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_rstn <= 1'b0;
                        addr_cnt <= '0;
                        word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                        chk_acc  <= '0;
`endif
                    end
                end

                ST_LEN_HI: begin
                    if (accept) begin
                        len_hi <= rx_data;
                        state  <= ST_LEN_LO;
                    end
                end

                ST_LEN_LO: begin
                    if (accept) begin
                        len <= len_now;
                        if ({1'b0, len_now} > CAPACITY) begin
                            state    <= ST_ERR;
                            rx_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else if (len_now == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            state       <= ST_CHK;
`else
                            state       <= ST_COMMIT;
                            rx_ready    <= 1'b0;
                            commit_wait <= 1'b0;
`endif
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                        chk_acc <= chk_acc ^ rx_data;
`endif
                        if (pk_idx == LAST_BYTE_IDX) begin
                            word_cnt <= word_cnt + LEN_W'(1);
                        end
                        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                            state       <= ST_CHK;
`else
                            state       <= ST_COMMIT;
                            rx_ready    <= 1'b0;
                            commit_wait <= 1'b0;
`endif
                        end
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (accept) begin
                        rx_ready <= 1'b0;
                        if (rx_data == chk_acc) begin
                            state       <= ST_COMMIT;
                            commit_wait <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end
                    end
                end
`endif

                // Two edges here: one for the last packed word to reach mem_we,
                // one for that write to land before the CPU is released.
                ST_COMMIT: begin
                    if (!commit_wait) begin
                        commit_wait <= 1'b1;
                    end else begin
                        state    <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_rstn <= 1'b1;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    rx_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - randomized self-checking bench for mem_loader against a frame-level model
// Honours LOADER_CHECKSUM_EN when the build defines it.
module tb_mem_loader;

    localparam int ADDR_W = 8;
    localparam int CAP    = 1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rstn;
    logic              busy;
    logic              done;
    logic              err;

    int checks    = 0;
    int failures  = 0;
    int consec    = 0;
    int rdy_drops = 0;
    logic we_prev = 1'b0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    logic [31:0]       frame_words [0:CAP];

    mem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rstn  (cpu_rstn),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
        if (mem_we && we_prev) consec++;
        we_prev = mem_we;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the falling edge right after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap_lo, input int gap_hi);
        int g;
        int t;
        g = $urandom_range(gap_hi, gap_lo);
        rx_valid = 1'b0;
        repeat (g) begin
            @(negedge clk);
            if (!rx_ready) rdy_drops++;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            check_val("rx_ready_wait", rx_ready, 1);
            rx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_rx_ready"}, rx_ready, 0);
        check_val({tag, "_mem_we"}, mem_we, 0);
        check_val({tag, "_mem_addr"}, mem_addr, 0);
        check_val({tag, "_mem_wdata"}, mem_wdata, 0);
        check_val({tag, "_cpu_rstn"}, cpu_rstn, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_err"}, err, 0);
    endtask

    // Model: N words land at addresses 0..N-1; the outcome is decided by the
    // length limit and, when enabled, by the XOR of all data bytes.
    task automatic run_frame(input int n, input int gap_lo, input int gap_hi, input bit bad_chk);
        logic [15:0] len;
        logic [7:0]  x;
        logic [7:0]  bt;
        bit          exp_err;
        bit          last_data;
        len       = 16'(n);
        x         = 8'h00;
        last_data = 1'b0;
        exp_err   = (n > CAP) || (CHK_EN && bad_chk);
        pulse_start();
        wr_addr_q.delete();
        wr_data_q.delete();
        rdy_drops = 0;
        send_byte(len[15:8], gap_lo, gap_hi);
        send_byte(len[7:0], gap_lo, gap_hi);
        if (n > CAP) begin
            check_val("len_err", err, 1);
            check_val("len_err_rx_ready", rx_ready, 0);
            check_val("len_err_cpu_rstn", cpu_rstn, 0);
            check_val("len_err_busy", busy, 0);
            repeat (3) @(negedge clk);
            check_val("len_err_writes", wr_data_q.size(), 0);
            check_val("len_err_cpu_rstn_hold", cpu_rstn, 0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            for (int b = 3; b >= 0; b--) begin
                bt = frame_words[i][b*8 +: 8];
                x  = x ^ bt;
                send_byte(bt, gap_lo, gap_hi);
                last_data = 1'b1;
            end
        end
        if (CHK_EN) begin
            send_byte(bad_chk ? (x ^ 8'h01) : x, gap_lo, gap_hi);
            last_data = 1'b0;
        end
        @(negedge clk);
        check_val("final_we", mem_we, last_data);
        check_val("done_early", done, 0);
        @(negedge clk);
        check_val("done", done, !exp_err);
        check_val("err", err, exp_err);
        check_val("cpu_rstn", cpu_rstn, !exp_err);
        check_val("busy_end", busy, 0);
        check_val("rx_ready_end", rx_ready, 0);
        check_val("rx_ready_hold", rdy_drops, 0);
        check_val("wr_count", wr_data_q.size(), n);
        for (int i = 0; i < n && i < wr_data_q.size(); i++) begin
            check_val("wr_addr", wr_addr_q[i], i);
            check_val("wr_data", wr_data_q[i], frame_words[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_rx_ready", rx_ready, 0);

        frame_words[0] = 32'h12345678;
        frame_words[1] = 32'h9ABCDEF0;
        run_frame(2, 0, 0, 1'b0);
        run_frame(2, 1, 1, 1'b0);

        run_frame(257, 0, 0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        frame_words[0] = 32'h11223344;
        run_frame(1, 0, 0, 1'b0);
        run_frame(1, 0, 0, 1'b1);
`endif

        frame_words[0] = 32'hCAFEF00D;
        frame_words[1] = 32'h01020304;
        pulse_start();
        send_byte(8'h00, 0, 0);
        send_byte(8'h02, 0, 0);
        for (int j = 0; j < 6; j++) begin
            n = j;
            send_byte(frame_words[n / 4][(3 - (n % 4)) * 8 +: 8], 0, 0);
        end
        rst = 1'b1;
        #1;
        check_reset_values("midload_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        frame_words[0] = 32'h0BADBEEF;
        run_frame(1, 0, 0, 1'b0);

        run_frame(0, 0, 0, 1'b0);

        for (int i = 0; i < CAP; i++) frame_words[i] = $urandom;
        run_frame(CAP, 0, 0, 1'b0);

        repeat (12) begin
            n = $urandom_range(6, 1);
            for (int i = 0; i < n; i++) frame_words[i] = $urandom;
            run_frame(n, 0, 2, CHK_EN && ($urandom_range(3, 0) == 0));
        end

        check_val("we_consecutive", consec, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
